// File: rtl/tx_framer_if.sv
// Gateway pull handshake plus framed byte stream for tx_framer.
// The master modport is the framer side; the slave modport is the gateway/sink side.
interface tx_framer_if #(
  parameter int jumbo_dw = 11
);
  logic                tx_req;
  logic [jumbo_dw-1:0] tx_len;
  logic                tx_ack;
  logic                tx_gate;
  logic [7:0]          tx_byte;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;

  modport master (
    input  tx_req, tx_len, tx_byte, out_ready,
    output tx_ack, tx_gate, out_data, out_valid, out_last, busy
  );

  modport slave (
    output tx_req, tx_len, tx_byte, out_ready,
    input  tx_ack, tx_gate, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/tx_framer.sv
// Frames a gateway reply as: 16-bit length, payload (zero-padded to min_len),
// then the inverted 16-bit ones-complement sum of payload and pad bytes.
module tx_framer #(
  parameter int jumbo_dw = 11,
  parameter int min_len  = 46,
  parameter int fifo_aw  = 2
) (
  input  logic         clk,
  input  logic         rst,
  tx_framer_if.master  bus
);
  localparam int depth = 2 ** fifo_aw;
  localparam logic [15:0]        min_len_w = 16'(min_len);
  localparam logic [fifo_aw+1:0] depth_w   = (fifo_aw + 2)'(depth);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, PAYLOAD, PAD, CK_HI, CK_LO
  } state_t;

  state_t state_reg, state_next;

  logic              rst_q_reg;
  logic [15:0]       len_reg;
  logic [15:0]       frame_len_reg;
  logic [15:0]       data_cnt_reg;
  logic [15:0]       pull_cnt_reg;
  logic [15:0]       sum_reg, sum_next;
  logic              odd_reg;
  logic              inflight_reg;

  logic [7:0]        fifo_mem [depth];
  logic [fifo_aw-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [fifo_aw:0]  count_reg;

  logic [15:0]       tx_len_w;
  logic [15:0]       data_cnt_inc;
  logic [fifo_aw+1:0] occ_w;
  logic [15:0]       ck_w;
  logic [15:0]       word_w;
  logic [16:0]       sum_raw;

  logic              ack;
  logic              gate;
  logic              pulling;
  logic              valid;
  logic              last;
  logic [7:0]        data;
  logic              xfer;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              data_xfer;

  assign tx_len_w     = 16'(bus.tx_len);
  assign data_cnt_inc = data_cnt_reg + 16'd1;
  assign occ_w        = {1'b0, count_reg} + {{(fifo_aw + 1){1'b0}}, inflight_reg};
  assign ck_w         = ~sum_reg;

  // Pulls run from the header onward; in-flight bytes count against FIFO room
  // so the FIFO can never overflow.
  assign pulling = ((state_reg == HDR_HI) || (state_reg == HDR_LO) || (state_reg == PAYLOAD))
                   && (pull_cnt_reg < len_reg);
  assign gate    = pulling && (occ_w < depth_w);

  assign xfer      = valid && bus.out_ready;
  assign fifo_wr   = inflight_reg;
  assign fifo_rd   = xfer && (state_reg == PAYLOAD);
  assign data_xfer = xfer && ((state_reg == PAYLOAD) || (state_reg == PAD));

  // Each byte is added at its big-endian position; end-around carry folded per add.
  assign word_w   = odd_reg ? {8'h00, data} : {data, 8'h00};
  assign sum_raw  = {1'b0, sum_reg} + {1'b0, word_w};
  assign sum_next = sum_raw[15:0] + {15'd0, sum_raw[16]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ack) state_next = HDR_HI;
      end
      HDR_HI: begin
        if (xfer) state_next = HDR_LO;
      end
      HDR_LO: begin
        if (xfer) begin
          if (len_reg != 16'd0)            state_next = PAYLOAD;
          else if (frame_len_reg != 16'd0) state_next = PAD;
          else                             state_next = CK_HI;
        end
      end
      PAYLOAD: begin
        if (xfer && (data_cnt_inc == len_reg)) begin
          state_next = (frame_len_reg > len_reg) ? PAD : CK_HI;
        end
      end
      PAD: begin
        if (xfer && (data_cnt_inc == frame_len_reg)) state_next = CK_HI;
      end
      CK_HI: begin
        if (xfer) state_next = CK_LO;
      end
      CK_LO: begin
        if (xfer) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic; the first IDLE cycle after reset never acks
  always_comb begin
    ack   = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    data  = 8'h00;
    case (state_reg)
      IDLE: begin
        ack = bus.tx_req && !rst_q_reg;
      end
      HDR_HI: begin
        valid = 1'b1;
        data  = frame_len_reg[15:8];
      end
      HDR_LO: begin
        valid = 1'b1;
        data  = frame_len_reg[7:0];
      end
      PAYLOAD: begin
        valid = (count_reg != '0);
        data  = valid ? fifo_mem[rd_ptr_reg] : 8'h00;
      end
      PAD: begin
        valid = 1'b1;
      end
      CK_HI: begin
        valid = 1'b1;
        data  = ck_w[15:8];
      end
      CK_LO: begin
        valid = 1'b1;
        last  = 1'b1;
        data  = ck_w[7:0];
      end
      default: begin
        valid = 1'b0;
      end
    endcase
  end

  assign bus.tx_ack    = ack;
  assign bus.tx_gate   = gate;
  assign bus.out_valid = valid;
  assign bus.out_last  = last;
  assign bus.out_data  = data;
  assign bus.busy      = (state_reg != IDLE);

  // Frame bookkeeping and checksum accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q_reg     <= 1'b1;
      len_reg       <= 16'd0;
      frame_len_reg <= 16'd0;
      data_cnt_reg  <= 16'd0;
      pull_cnt_reg  <= 16'd0;
      sum_reg       <= 16'd0;
      odd_reg       <= 1'b0;
      inflight_reg  <= 1'b0;
    end else begin
      rst_q_reg    <= 1'b0;
      inflight_reg <= gate;
      if (ack) begin
        len_reg       <= tx_len_w;
        frame_len_reg <= (tx_len_w < min_len_w) ? min_len_w : tx_len_w;
        data_cnt_reg  <= 16'd0;
        pull_cnt_reg  <= 16'd0;
        sum_reg       <= 16'd0;
        odd_reg       <= 1'b0;
      end else begin
        if (gate) pull_cnt_reg <= pull_cnt_reg + 16'd1;
        if (data_xfer) begin
          data_cnt_reg <= data_cnt_inc;
          sum_reg      <= sum_next;
          odd_reg      <= ~odd_reg;
        end
      end
    end
  end

  // Byte FIFO control; pointers wrap naturally at the depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_reg] <= bus.tx_byte;
  end
endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer: one line per compared transaction, gateway
// responder model, FIFO occupancy model and hand-computed frame vectors.
module tb_tx_framer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_framer_if #(.jumbo_dw(11)) ifc0 ();
  tx_framer_if #(.jumbo_dw(11)) ifc1 ();

  tx_framer #(.jumbo_dw(11), .min_len(46), .fifo_aw(2)) dut (
    .clk(clk), .rst(rst), .bus(ifc0)
  );
  tx_framer #(.jumbo_dw(11), .min_len(1), .fifo_aw(2)) dut_min1 (
    .clk(clk), .rst(rst), .bus(ifc1)
  );

  logic        sel;
  logic        req;
  logic [10:0] len_v;
  logic [7:0]  byte_v;
  logic        rdy;

  assign ifc0.tx_req    = req & ~sel;
  assign ifc1.tx_req    = req & sel;
  assign ifc0.tx_len    = len_v;
  assign ifc1.tx_len    = len_v;
  assign ifc0.tx_byte   = byte_v;
  assign ifc1.tx_byte   = byte_v;
  assign ifc0.out_ready = rdy;
  assign ifc1.out_ready = rdy;

  logic       m_ack, m_gate, m_valid, m_last, m_busy;
  logic [7:0] m_data;
  assign m_ack   = sel ? ifc1.tx_ack    : ifc0.tx_ack;
  assign m_gate  = sel ? ifc1.tx_gate   : ifc0.tx_gate;
  assign m_valid = sel ? ifc1.out_valid : ifc0.out_valid;
  assign m_last  = sel ? ifc1.out_last  : ifc0.out_last;
  assign m_busy  = sel ? ifc1.busy      : ifc0.busy;
  assign m_data  = sel ? ifc1.out_data  : ifc0.out_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] payload [0:127];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int  n_gate;
  int  n_last;
  bit  last_final;

  // Gateway: a byte requested by tx_gate in cycle t is presented during cycle t+1
  logic ack_q = 1'b0;
  logic gate_q = 1'b0;
  int   gw_ptr = 0;
  always @(posedge clk) begin
    ack_q  <= m_ack;
    gate_q <= m_gate;
  end
  always @(negedge clk) begin
    if (ack_q) gw_ptr = 0;
    if (gate_q) begin
      byte_v = (gw_ptr < 128) ? payload[gw_ptr] : 8'h00;
      gw_ptr = gw_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic [15:0] model_ck(input int len, input int flen);
    int unsigned s;
    logic [7:0] hi, lo;
    s = 0;
    for (int i = 0; i < flen; i += 2) begin
      hi = (i < len) ? payload[i] : 8'h00;
      lo = ((i + 1 < flen) && (i + 1 < len)) ? payload[i+1] : 8'h00;
      s += {16'd0, hi, lo};
    end
    while ((s >> 16) != 0) s = (s & 32'h0000FFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic build_exp(input int len, input int flen, input logic [15:0] ck);
    logic [15:0] l16;
    l16 = 16'(flen);
    exp_q.delete();
    exp_q.push_back(l16[15:8]);
    exp_q.push_back(l16[7:0]);
    for (int i = 0; i < len; i++) exp_q.push_back(payload[i]);
    for (int i = len; i < flen; i++) exp_q.push_back(8'h00);
    exp_q.push_back(ck[15:8]);
    exp_q.push_back(ck[7:0]);
  endtask

  task automatic load72();
    logic [7:0] head [0:7];
    head = '{8'h12, 8'h21, 8'h12, 8'h21, 8'h34, 8'h56, 8'h78, 8'h9a};
    for (int i = 0; i < 128; i++) payload[i] = (i < 8) ? head[i] : 8'((i * 37) + 5);
  endtask

  task automatic run_frame(input int len, input int rdy_pct, input bit hold, input bit pre_acked);
    int occ;
    int cyc;
    bit gate_prev, pv, pr, pl, rd;
    logic [7:0] pd;
    got_q.delete();
    n_gate = 0; n_last = 0; last_final = 0;
    len_v = 11'(len);
    req = 1'b1;
    occ = 0; gate_prev = 0; pv = 0; pr = 1; pl = 0; pd = 8'h00;
    for (cyc = 0; cyc < 5000 && got_q.size() < exp_q.size(); cyc++) begin
      @(negedge clk);
      if (pre_acked && cyc == 0) chk("b2b_busy_after_idle", m_busy, 1);
      if (m_busy && !hold) req = 1'b0;
      rdy = ($urandom_range(99) < rdy_pct);
      if (m_gate) n_gate++;
      if (pv && !pr) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, pd);
        chk("stall_last", m_last, pl);
      end
      chk("occ_max4", 32'(occ <= 4), 1);
      if (m_gate) chk("gate_room", 32'((occ + gate_prev) < 4), 1);
      rd = m_valid && rdy && (got_q.size() >= 2) && (got_q.size() < 2 + len);
      if (m_valid && rdy) begin
        got_q.push_back(m_data);
        if (m_last) begin
          n_last++;
          last_final = (got_q.size() == exp_q.size());
        end
      end
      occ = occ + int'(gate_prev) - int'(rd);
      gate_prev = m_gate; pv = m_valid; pr = rdy; pd = m_data; pl = m_last;
    end
    rdy = 1'b1;
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_last_once"}, n_last, 1);
    chk({tag, "_last_final"}, last_final, 1);
    $display("frame %s: %0d bytes, %0d pulls", tag, got_q.size(), n_gate);
  endtask

  initial begin
    sel = 1'b0; req = 1'b1; len_v = 11'd72; byte_v = 8'h00; rdy = 1'b1;
    rst = 1'b1;
    load72();
    repeat (3) @(negedge clk);
    chk("rst_ack", m_ack, 0);
    chk("rst_gate", m_gate, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk);

    // 72-byte frame, sink always ready
    build_exp(72, 72, model_ck(72, 72));
    run_frame(72, 100, 0, 0);
    compare_stream("f72");
    chk("f72_pulls", n_gate, 72);
    repeat (2) @(negedge clk);

    // 4-byte frame padded to 46, request held to start the next frame
    for (int i = 0; i < 4; i++) payload[i] = 8'(i + 1);
    build_exp(4, 46, 16'hFBF9);
    run_frame(4, 100, 1, 0);
    compare_stream("f4");
    chk("f4_pulls", n_gate, 4);
    len_v = 11'd0;
    @(negedge clk);
    chk("b2b_idle_busy", m_busy, 0);
    chk("b2b_idle_ack", m_ack, 1);

    // Zero-length frame: all pad, checksum FFFF
    build_exp(0, 46, 16'hFFFF);
    run_frame(0, 100, 0, 1);
    compare_stream("f0");
    chk("f0_pulls", n_gate, 0);
    repeat (2) @(negedge clk);

    // min_len=1 instance: odd trailing byte and end-around carry
    sel = 1'b1;
    for (int i = 0; i < 3; i++) payload[i] = 8'hFF;
    build_exp(3, 3, 16'h00FF);
    run_frame(3, 100, 0, 0);
    compare_stream("f3");
    chk("f3_pulls", n_gate, 3);
    sel = 1'b0;
    repeat (2) @(negedge clk);

    // 72-byte frame with a stalling sink
    load72();
    build_exp(72, 72, model_ck(72, 72));
    run_frame(72, 30, 0, 0);
    compare_stream("f72_bp");
    chk("f72_bp_pulls", n_gate, 72);
    repeat (2) @(negedge clk);

    // Reset in mid-payload with the request still pending
    len_v = 11'd72; req = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_busy_before", m_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ack", m_ack, 0);
    chk("abort_gate", m_gate, 0);
    chk("abort_valid", m_valid, 0);
    chk("abort_last", m_last, 0);
    chk("abort_busy", m_busy, 0);
    chk("abort_data", m_data, 0);
    @(negedge clk);
    chk("abort_reack", m_ack, 1);
    build_exp(72, 72, model_ck(72, 72));
    run_frame(72, 100, 0, 1);
    compare_stream("f72_after_rst");
    chk("f72_after_rst_pulls", n_gate, 72);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 Parameter jumbo_dw, default 11: width of the packet length from the gateway.
REQ-002 Parameter min_len, default 46: minimum payload bytes per frame; shorter payloads are zero-padded.
REQ-003 Parameter fifo_aw, default 2: address width of the internal byte FIFO (depth 2**fifo_aw).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 tx_req  input  1  gateway has a reply packet pending.
REQ-007 tx_len  input  jumbo_dw  reply payload byte count; valid while tx_req high.
REQ-008 tx_ack  output  1  one-cycle pulse accepting the request.
REQ-009 tx_gate  output  1  pulls one byte from the gateway.
REQ-010 tx_byte  input  8  gateway byte; valid exactly one cycle after the tx_gate cycle that requested it.
REQ-011 out_data  output  8  framed byte stream.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  sink accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-014 out_last  output  1  marks the final byte of a frame.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The state machine SHALL have states IDLE, HDR_HI, HDR_LO, PAYLOAD, PAD, CK_HI, CK_LO.
- Output states advance only on a transfer.
- CK_LO transfer returns to IDLE.
REQ-017 In IDLE with tx_req high, the block SHALL pulse tx_ack for one cycle, capture tx_len, and enter HDR_HI on the next cycle.
REQ-018 Frame length SHALL be L = max(tx_len, min_len), zero-extended to 16 bits.
REQ-019 HDR_HI/HDR_LO SHALL present L[15:8] then L[7:0].
REQ-020 PAYLOAD SHALL present tx_len FIFO bytes in arrival order, then go to PAD if L > tx_len, else to CK_HI.
- tx_len = 0 SHALL skip PAYLOAD entirely.
REQ-021 PAD SHALL present L - tx_len bytes of 0x00.
REQ-022 CK_HI/CK_LO SHALL present C[15:8] then C[7:0], and out_last SHALL be high only with CK_LO.
REQ-023 C SHALL be computed as follows:
- Take the 16-bit ones-complement sum of all PAYLOAD and PAD bytes as big-endian words (even byte index = high byte; an odd trailing byte is paired with 0x00).
- Fold all end-around carries into the sum.
- Bitwise-invert the result to give C.
REQ-024 Byte pulls SHALL run as follows:
- Pulls are issued from HDR_HI onward until tx_len pulls are done.
- tx_gate SHALL assert only while FIFO occupancy + in-flight pulls < FIFO depth.
- The FIFO SHALL never overflow.
- tx_gate SHALL assert exactly tx_len times per frame.
REQ-025 In PAYLOAD with the FIFO empty, out_valid SHALL be low.
REQ-026 A FIFO write and read in the same cycle SHALL leave occupancy unchanged.
REQ-027 Pointers SHALL wrap modulo the FIFO depth.
REQ-028 out_data/out_valid/out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-029 tx_req is ignored outside IDLE.
- A request held high after CK_LO SHALL be acked on the first IDLE cycle.
- Back-to-back frames have exactly one IDLE cycle between them.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL:
- Enter IDLE.
- Empty the FIFO.
- Clear the pull counter and checksum accumulator.
- Force tx_ack, tx_gate, out_valid, out_last, busy and out_data to 0 from the next cycle.
REQ-031 A tx_byte arriving on the cycle after reset, from a pre-reset tx_gate, SHALL be discarded.
REQ-032 Reset mid-frame SHALL abort the frame without completing it; the next request SHALL produce a fully correct frame.

Verification
REQ-033 min_len=46, tx_len=72, payload 12 21 12 21 34 56 78 9a ..., out_ready=1 ->
- Stream is 00 48, then the 72 bytes, then the checksum.
- tx_gate is high for exactly 72 cycles.
- Total 76 transfers; out_last only on the 76th.
REQ-034 min_len=46, tx_len=4, payload 01 02 03 04 ->
- Stream is 00 2E, 01 02 03 04, 42 x 00, FB F9.
- 50 transfers total.
REQ-035 min_len=1, tx_len=3, payload FF FF FF -> sum 0xFFFF+0xFF00 folds to 0xFF00, so the stream is 00 03, FF FF FF, 00 FF.
REQ-036 tx_len=0, min_len=46 ->
- tx_ack pulses and tx_gate never asserts.
- Stream is 00 2E, 46 x 00, FF FF.
REQ-037 tx_len=72 with out_ready pseudo-random at 30% duty ->
- Byte sequence is identical to REQ-033.
- FIFO occupancy never exceeds 4.
- tx_gate is low whenever occupancy + in-flight = 4.
REQ-038 rst pulsed for 1 cycle in PAYLOAD, with tx_req still high ->
- All outputs are 0 the following cycle.
- The next frame is bit-exact to REQ-033.
